// File: rtl/sprite_pkg.sv
// sprite_pkg: screen constants, colour type and per-sprite state record for sprite_engine.
package sprite_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int ANIM_MAX_W = 16;
  typedef logic [11:0] color_t;
  typedef struct packed {
    logic [10:0]           x;
    logic [9:0]            y;
    logic [3:0]            vx;
    logic                  en;
    logic [ANIM_MAX_W-1:0] anim_cnt;
  } spr_state_t;
endpackage

// File: rtl/sprite_agu.sv
// sprite_agu: one sprite's state, per-frame motion and registered hit/texel-address stage.
// SPRITE_MIRROR_EN: sprites moving left read their texel columns mirrored.
module sprite_agu
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 32,
  parameter int NUM_FRAMES  = 8,
  parameter int ANIM_SHIFT  = 2,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick_i,
  input  logic              cfg_we_i,
  input  logic [10:0]       cfg_x_i,
  input  logic [9:0]        cfg_y_i,
  input  logic [3:0]        cfg_vx_i,
  input  logic              cfg_en_i,
  input  logic [9:0]        pixel_x_i,
  input  logic [9:0]        pixel_y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              hit_o
);
  localparam int CW = $clog2(SPR_W);
  localparam int AW = $clog2(NUM_FRAMES) + ANIM_SHIFT;
  localparam logic signed [11:0] SPAN_X = 12'(SPR_W << SCALE_SHIFT);
  localparam logic signed [10:0] SPAN_Y = 11'(SPR_H << SCALE_SHIFT);
  localparam logic signed [11:0] X_MAX = 12'(H_RES);
  localparam logic [10:0] X_LO = 11'(-(SPR_W << SCALE_SHIFT));
  localparam logic [10:0] X_HI = 11'(H_RES - 1);
  localparam logic [ANIM_MAX_W-1:0] ANIM_MASK = ANIM_MAX_W'((1 << AW) - 1);

  spr_state_t s_q, s_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic hit_q, hit_d;
  logic signed [11:0] nx, dx;
  logic signed [10:0] dy;
  logic [CW-1:0] col, col_m;
  logic [10:0] row;
  logic [ANIM_MAX_W-1:0] frame;

  assign nx = $signed({s_q.x[10], s_q.x}) + $signed({{8{s_q.vx[3]}}, s_q.vx});

  // A write to this sprite overrides the frame move in the same cycle.
  always_comb begin
    s_d = s_q;
    if (cfg_we_i) begin
      s_d.x = cfg_x_i;
      s_d.y = cfg_y_i;
      s_d.vx = cfg_vx_i;
      s_d.en = cfg_en_i;
      s_d.anim_cnt = '0;
    end else if (frame_tick_i && s_q.en) begin
      s_d.x = (nx >= X_MAX) ? X_LO : (nx < -SPAN_X) ? X_HI : nx[10:0];
      s_d.anim_cnt = (s_q.anim_cnt + 1'b1) & ANIM_MASK;
    end
  end

  assign dx = $signed({2'b00, pixel_x_i}) - $signed({s_q.x[10], s_q.x});
  assign dy = $signed({1'b0, pixel_y_i}) - $signed({1'b0, s_q.y});
  assign hit_d = s_q.en && dx >= 12'sd0 && dx < SPAN_X && dy >= 11'sd0 && dy < SPAN_Y;
  assign col = CW'($unsigned(dx) >> SCALE_SHIFT);
  assign row = $unsigned(dy) >> SCALE_SHIFT;
  assign frame = s_q.anim_cnt >> ANIM_SHIFT;
`ifdef SPRITE_MIRROR_EN
  assign col_m = s_q.vx[3] ? ~col : col;
`else
  assign col_m = col;
`endif
  assign addr_d = hit_d ? ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H) + ADDR_W'(row) * ADDR_W'(SPR_W)
                          + ADDR_W'(col_m) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      addr_q <= '0;
      hit_q <= 1'b0;
    end else begin
      s_q <= s_d;
      addr_q <= addr_d;
      hit_q <= hit_d;
    end
  end

  assign addr_o = addr_q;
  assign hit_o = hit_q;
endmodule

// File: rtl/sprite_engine.sv
// sprite_engine: multi-sprite address generator and priority/colour-key compositor, 3-clk latency.
// SPRITE_MIRROR_EN (see sprite_agu) mirrors left-moving sprites.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int     NUM_SPR     = 4,
  parameter int     SPR_W       = 64,
  parameter int     SPR_H       = 32,
  parameter int     NUM_FRAMES  = 8,
  parameter int     ANIM_SHIFT  = 2,
  parameter int     SCALE_SHIFT = 1,
  parameter color_t KEY_COLOR   = 12'h0F0,
  parameter int     ADDR_W      = 18,
  parameter int     BG_W        = 320,
  localparam int    IDX_W       = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic                      video_on,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [10:0]               cfg_x,
  input  logic [9:0]                cfg_y,
  input  logic [3:0]                cfg_vx,
  input  logic                      cfg_en,
  output logic [NUM_SPR*ADDR_W-1:0] spr_addr,
  input  logic [NUM_SPR*12-1:0]     spr_data,
  output logic [ADDR_W-1:0]         bg_addr,
  input  logic [11:0]               bg_data,
  output logic [NUM_SPR-1:0]        spr_hit,
  output logic [11:0]               rgb
);
  logic [ADDR_W-1:0] bg_addr_q, bg_addr_d;
  logic [NUM_SPR-1:0] hit2_q;
  logic von1_q, von2_q;
  color_t rgb_q, pick;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    sprite_agu #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES),
      .ANIM_SHIFT(ANIM_SHIFT), .SCALE_SHIFT(SCALE_SHIFT), .ADDR_W(ADDR_W)
    ) u_agu (
      .clk(clk),
      .reset(reset),
      .frame_tick_i(frame_tick),
      .cfg_we_i(cfg_we && cfg_idx == IDX_W'(i)),
      .cfg_x_i(cfg_x),
      .cfg_y_i(cfg_y),
      .cfg_vx_i(cfg_vx),
      .cfg_en_i(cfg_en),
      .pixel_x_i(pixel_x),
      .pixel_y_i(pixel_y),
      .addr_o(spr_addr[i*ADDR_W +: ADDR_W]),
      .hit_o(spr_hit[i])
    );
  end

  assign bg_addr_d = ADDR_W'(pixel_y >> SCALE_SHIFT) * ADDR_W'(BG_W) + ADDR_W'(pixel_x >> SCALE_SHIFT);

  // Scan from lowest priority up so sprite 0 is written last and wins.
  always_comb begin
    pick = bg_data;
    for (int i = NUM_SPR - 1; i >= 0; i--)
      if (hit2_q[i] && spr_data[i*12 +: 12] != KEY_COLOR) pick = spr_data[i*12 +: 12];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bg_addr_q <= '0;
      hit2_q <= '0;
      von1_q <= 1'b0;
      von2_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      bg_addr_q <= bg_addr_d;
      hit2_q <= spr_hit;
      von1_q <= video_on;
      von2_q <= von1_q;
      rgb_q <= von2_q ? pick : 12'h000;
    end
  end

  assign bg_addr = bg_addr_q;
  assign rgb = rgb_q;
endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: directed + randomized checks of sprite_engine against an integer reference model.
module tb_sprite_engine;
  localparam int N = 4, SW = 64, SH = 32, NF = 8, AS = 2, SS = 1, AW = 18, BGW = 320;
  localparam int SPAN_X = SW << SS, SPAN_Y = SH << SS;
  localparam logic [11:0] KEY = 12'h0F0;

  logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, video_on = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0, cfg_y = '0;
  logic [1:0] cfg_idx = '0;
  logic [10:0] cfg_x = '0;
  logic [3:0] cfg_vx = '0;
  logic [N*AW-1:0] spr_addr;
  logic [N*12-1:0] spr_data;
  logic [AW-1:0] bg_addr;
  logic [11:0] bg_data, rgb;
  logic [N-1:0] spr_hit;

  int checks = 0, errors = 0;
  int mx[N], my[N], mvx[N], men[N], man[N];
  logic use_force = 1'b0;
  logic [11:0] f_spr[N];
  logic [11:0] f_bg;

  always #5 clk = ~clk;

  sprite_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_vx(cfg_vx), .cfg_en(cfg_en), .spr_addr(spr_addr), .spr_data(spr_data),
    .bg_addr(bg_addr), .bg_data(bg_data), .spr_hit(spr_hit), .rgb(rgb)
  );

  function automatic logic [11:0] shash(int i, int a);
    if (a % 5 == 0) return KEY;
    return 12'(a * 37 + i * 101 + 5);
  endfunction

  function automatic logic [11:0] bhash(int a);
    return 12'(a * 13 + 7);
  endfunction

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      spr_data[i*12 +: 12] <= use_force ? f_spr[i] : shash(i, int'(spr_addr[i*AW +: AW]));
    bg_data <= use_force ? f_bg : bhash(int'(bg_addr));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 0; men[i] = 0; man[i] = 0;
    end
  endtask

  task automatic model_tick();
    int nx;
    for (int i = 0; i < N; i++)
      if (men[i] != 0) begin
        nx = mx[i] + mvx[i];
        mx[i] = (nx >= 640) ? -SPAN_X : (nx < -SPAN_X) ? 639 : nx;
        man[i] = (man[i] + 1) % (NF << AS);
      end
  endtask

  task automatic cfg(input int idx, input int x, input int y, input int vx, input int en, input bit tick);
    @(negedge clk);
    cfg_idx = 2'(idx); cfg_x = 11'(x); cfg_y = 10'(y); cfg_vx = 4'(vx); cfg_en = en[0];
    cfg_we = 1'b1; frame_tick = tick;
    @(negedge clk);
    cfg_we = 1'b0; frame_tick = 1'b0;
    if (tick) model_tick();
    mx[idx] = x; my[idx] = y; mvx[idx] = vx; men[idx] = en; man[idx] = 0;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    model_tick();
  endtask

  task automatic pix(input int px, input int py, input bit von);
    logic [N-1:0] eh;
    int ea[N];
    int dx, dy, col, eb;
    logic [11:0] er, d;
    bit found;
    @(negedge clk);
    pixel_x = 10'(px); pixel_y = 10'(py); video_on = von;
    for (int i = 0; i < N; i++) begin
      dx = px - mx[i]; dy = py - my[i];
      eh[i] = men[i] != 0 && dx >= 0 && dx < SPAN_X && dy >= 0 && dy < SPAN_Y;
      col = dx >> SS;
`ifdef SPRITE_MIRROR_EN
      if (mvx[i] < 0) col = SW - 1 - col;
`endif
      ea[i] = eh[i] ? (man[i] >> AS) * SW * SH + (dy >> SS) * SW + col : 0;
    end
    eb = (py >> SS) * BGW + (px >> SS);
    er = use_force ? f_bg : bhash(eb);
    found = 0;
    for (int i = 0; i < N; i++) begin
      d = use_force ? f_spr[i] : shash(i, ea[i]);
      if (!found && eh[i] && d != KEY) begin er = d; found = 1; end
    end
    if (!von) er = 12'h000;
    @(posedge clk); #1;
    chk("spr_hit", 32'(spr_hit), 32'(eh));
    for (int i = 0; i < N; i++) chk($sformatf("spr_addr%0d", i), 32'(spr_addr[i*AW +: AW]), 32'(ea[i]));
    chk("bg_addr", 32'(bg_addr), 32'(eb));
    @(posedge clk); @(posedge clk); #1;
    chk("rgb", 32'(rgb), 32'(er));
  endtask

  initial begin
    int r, k, px, py;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", 32'(rgb), 0);
    chk("reset_hit", 32'(spr_hit), 0);
    chk("reset_addr", 32'(spr_addr), 0);
    chk("reset_bg", 32'(bg_addr), 0);
    @(negedge clk) reset = 1'b0;

    cfg(0, 100, 160, 0, 1, 0);
    pix(100, 160, 1);
    pix(227, 223, 1);
    pix(228, 160, 1);
    pix(99, 160, 1);

    cfg(0, 630, 160, 3, 1, 0);
    tick();
    pix(633, 160, 1);
    pix(632, 160, 1);
    repeat (3) tick();
    pix(0, 160, 1);
    cfg(0, -127, 160, -2, 1, 0);
    pix(0, 160, 1);
    tick();
    pix(639, 160, 1);

    cfg(0, 100, 160, 0, 1, 0);
    cfg(1, 100, 160, 0, 1, 0);
    use_force = 1'b1;
    f_spr[0] = KEY; f_spr[1] = 12'hABC; f_spr[2] = 12'h0; f_spr[3] = 12'h0; f_bg = 12'h123;
    pix(110, 170, 1);
    f_spr[0] = 12'h456;
    pix(110, 170, 1);
    pix(300, 300, 1);
    pix(110, 170, 0);
    use_force = 1'b0;

    cfg(1, 0, 0, 0, 0, 0);
    cfg(0, 100, 160, 0, 1, 0);
    repeat (12) tick();
    pix(100, 160, 1);
    pix(150, 200, 1);
    cfg(0, 100, 160, 1, 1, 0);
    cfg(1, 200, 100, 2, 1, 1);
    pix(101, 160, 1);
    pix(200, 100, 1);

    cfg(0, 100, 160, -1, 1, 0);
    pix(100, 160, 1);
    pix(120, 170, 1);

    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)
        cfg(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 850)) - 150,
            int'($urandom_range(0, 500)), int'($urandom_range(0, 15)) - 8,
            int'($urandom_range(0, 3)) != 0, $urandom_range(0, 1) == 1);
      else if (r == 1) tick();
      else begin
        k = int'($urandom_range(0, N - 1));
        if ($urandom_range(0, 1) == 1) begin
          px = mx[k] + int'($urandom_range(0, SPAN_X + 10)) - 5;
          py = my[k] + int'($urandom_range(0, SPAN_Y + 10)) - 5;
        end else begin
          px = int'($urandom_range(0, 639));
          py = int'($urandom_range(0, 479));
        end
        px = px < 0 ? 0 : px > 639 ? 639 : px;
        py = py < 0 ? 0 : py > 479 ? 479 : py;
        pix(px, py, $urandom_range(0, 7) != 0);
      end
    end

    cfg(0, 100, 160, 0, 1, 0);
    use_force = 1'b1;
    f_spr[0] = 12'h456; f_bg = 12'h123;
    pix(200, 200, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rgb", 32'(rgb), 0);
    chk("async_addr", 32'(spr_addr), 0);
    chk("async_hit", 32'(spr_hit), 0);
    chk("async_bg", 32'(bg_addr), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    model_reset();
    pix(200, 200, 1);
    use_force = 1'b0;
    pix(5, 7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_engine.md
# sprite_engine

Parametrised multi-sprite address generator and compositor for the 640x480 VGA path. Holds per-sprite position, velocity and animation state, moves every sprite once per video frame, generates per-sprite texel addresses for the current pixel, and merges the returned colours over the background by fixed priority with colour-key transparency. Sits between the VGA sync generator / frame-buffer SRAMs and the VGA colour output register.

## Interface
- NUM_SPR, 4: number of sprites, 1..8; sprite 0 has highest priority.
- SPR_W, 64: sprite width in texels, power of two.
- SPR_H, 32: sprite height in texels.
- NUM_FRAMES, 8: animation frames per sprite, power of two.
- ANIM_SHIFT, 2: animation frame advances every 2^ANIM_SHIFT video frames.
- SCALE_SHIFT, 1: each texel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels.
- KEY_COLOR, 12'h0F0: transparent colour.
- ADDR_W, 18: sprite and background address width.
- BG_W, 320: background buffer width; background is scaled by SCALE_SHIFT.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- pixel_x  in  10  current x, 0..639
- pixel_y  in  10  current y, 0..479
- video_on  in  1  visible-region flag
- cfg_we  in  1  write strobe for one sprite's state
- cfg_idx  in  $clog2(NUM_SPR)  sprite to write
- cfg_x  in  11  signed left-edge x, screen pixels
- cfg_y  in  10  top-edge y, screen pixels
- cfg_vx  in  4  signed x velocity, pixels per frame
- cfg_en  in  1  sprite enable
- spr_addr  out  NUM_SPR*ADDR_W  per-sprite texel address, sprite i at [i*ADDR_W +: ADDR_W]
- spr_data  in  NUM_SPR*12  per-sprite texel data, 1-cycle synchronous read
- bg_addr  out  ADDR_W  background address
- bg_data  in  12  background data, 1-cycle synchronous read
- spr_hit  out  NUM_SPR  registered per-sprite region flag (stage 1)
- rgb  out  12  composed colour

## Operation
- Per-sprite registers: x (signed 11), y (10), vx (signed 4), en, anim_cnt (log2(NUM_FRAMES)+ANIM_SHIFT bits). All reset to 0.
- cfg_we: loads x, y, vx, en of sprite cfg_idx and clears its anim_cnt.
- frame_tick, for each enabled sprite: x <= x + vx; anim_cnt <= anim_cnt + 1 (wraps).
  - If x + vx >= 640, x <= -(SPR_W<<SCALE_SHIFT).
  - If x + vx < -(SPR_W<<SCALE_SHIFT), x <= 639.
- cfg_we and frame_tick in the same cycle: cfg_we wins for sprite cfg_idx. Other sprites move normally.
- Hit for sprite i requires all of:
  - en
  - x <= pixel_x < x + (SPR_W<<SCALE_SHIFT), evaluated as signed 12-bit
  - y <= pixel_y < y + (SPR_H<<SCALE_SHIFT)
- Texel lookup:
  - col = (pixel_x - x) >> SCALE_SHIFT; row = (pixel_y - y) >> SCALE_SHIFT.
  - frame = anim_cnt >> ANIM_SHIFT.
  - addr = frame*SPR_W*SPR_H + row*SPR_W + col.
  - When there is no hit, addr = 0.
- bg_addr = (pixel_y>>SCALE_SHIFT)*BG_W + (pixel_x>>SCALE_SHIFT).
- Compose: rgb = spr_data of the lowest i whose delayed hit is set and whose data != KEY_COLOR. If there is none, rgb = bg_data.
- When delayed video_on = 0, rgb = 12'h000.

## Timing
- Cycle n: pixel_x/pixel_y/video_on presented.
- Edge n+1: spr_addr, bg_addr, spr_hit and video_on stage 1 are registered.
- Edge n+2: memories return data; hit and video_on advance to stage 2.
- Edge n+3: rgb registered. Total latency is 3 clk.
- Pixel coordinates must be held at least 4 clk per pixel (pixel_tick at clk/4).
- Position and animation updates take effect on the cycle after frame_tick.
- reset mid-line clears all state immediately. rgb, spr_hit and all addresses read 0 until reset is released.

## Configuration
- SPRITE_MIRROR_EN defined: a sprite with vx < 0 uses col' = SPR_W-1-col, so it faces its direction of travel.
- SPRITE_MIRROR_EN undefined: no mirroring; col is used as is.

## Structure
- Shared package sprite_pkg holds:
  - screen constants H_RES=640, V_RES=480
  - the colour type (12-bit)
  - the sprite state record (x, y, vx, en, anim_cnt)
- Natural sub-module: sprite_agu, one instance per sprite. It holds one sprite's state and motion, plus the hit/address stage.
- Top level holds the background AGU, pipeline delays and priority compositor.

## Test plan
- Write sprite 0 x=100, y=160, vx=0, en=1; pixel (100,160) -> spr_addr0=0, spr_hit[0]=1. Pixel (227,223) -> addr0 = 31*64+63 = 2047. Pixel (228,160) -> spr_hit[0]=0, addr0=0.
- Sprite 0 x=630, vx=+3; one frame_tick -> x=633; three more frame_ticks -> x=-128 (wrap). Repeat with vx=-2 from x=-127 -> x=639.
- Sprites 0 and 1 overlap at the same pixel; spr_data0=KEY_COLOR, spr_data1=12'hABC, bg=12'h123 -> rgb=12'hABC three cycles later. With spr_data0=12'h456 -> rgb=12'h456.
- 12 frame_ticks with ANIM_SHIFT=2 -> frame index 3, address base 3*2048=6144. cfg_we together with frame_tick on sprite 1 -> sprite 1 takes cfg values with anim_cnt=0; sprite 0 still moves.
- video_on=0 with a hit present -> rgb=0. Assert reset mid-frame -> rgb and all addresses 0 asynchronously.
- SPRITE_MIRROR_EN defined, vx=-1, pixel at col 0 -> address 63; undefined -> address 0.
